// File: rtl/spi_slave.sv
// spi_slave: byte-oriented SPI slave running on the local clock.
// sclk/ss/mosi are oversampled through 2-flop synchronizers; sclk and ss
// also keep a history flop for edge detection. Received bytes go out on a
// valid/ack handshake; transmit bytes come from a single-entry holding buffer.
// Bit order is MSB first; mode is fixed by the cpol/cpha parameters.
module spi_slave #(
  parameter logic cpol = 1'b0,
  parameter logic cpha = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sclk,
  input  logic       ss,
  input  logic       mosi,
  output logic       miso,
  input  logic [7:0] tx_data,
  input  logic       tx_load,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  // synchronizer chains
  logic        sclk_meta, sclk_sync, sclk_hist;
  logic        ss_meta, ss_sync, ss_hist;
  logic        mosi_meta, mosi_sync;

  // edge detects derived from synchronized values only
  logic        lead_edge, trail_edge, ss_fall;
  logic        sample_edge, shift_edge;

  // datapath
  logic [7:0]  shift_tx;
  logic [7:0]  shift_rx;
  logic [7:0]  tx_buf;
  logic [3:0]  bit_cnt;
  logic [7:0]  rx_byte;

  // FSM-issued strobes
  logic        do_load;
  logic        do_sample;
  logic        do_shift;
  logic        do_reload;
  logic        byte_done;
  logic        clr_cnt;
  logic        reload_any;

  // Synchronize the asynchronous SPI pins and keep history for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_meta <= cpol;
      sclk_sync <= cpol;
      sclk_hist <= cpol;
      ss_meta   <= 1'b1;
      ss_sync   <= 1'b1;
      ss_hist   <= 1'b1;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else begin
      sclk_meta <= sclk;
      sclk_sync <= sclk_meta;
      sclk_hist <= sclk_sync;
      ss_meta   <= ss;
      ss_sync   <= ss_meta;
      ss_hist   <= ss_sync;
      mosi_meta <= mosi;
      mosi_sync <= mosi_meta;
    end
  end

  // Classify synchronized sclk transitions into sample/shift edges for the mode
  always_comb begin
    lead_edge   = (sclk_sync != cpol) && (sclk_hist == cpol);
    trail_edge  = (sclk_sync == cpol) && (sclk_hist != cpol);
    ss_fall     = ss_hist && !ss_sync;
    sample_edge = cpha ? trail_edge : lead_edge;
    shift_edge  = cpha ? lead_edge : trail_edge;
    rx_byte     = {shift_rx[6:0], mosi_sync};
    reload_any  = do_load || do_reload;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state and datapath strobes
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    do_reload  = 1'b0;
    byte_done  = 1'b0;
    clr_cnt    = 1'b0;
    case (state)
      IDLE: begin
        clr_cnt = 1'b1;
        if (ss_fall) begin
          state_next = LOAD;
        end
      end
      LOAD: begin
        do_load    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (ss_sync) begin
          // deselect: any partial byte is simply dropped
          state_next = IDLE;
          clr_cnt    = 1'b1;
        end else begin
          if (sample_edge) begin
            do_sample = 1'b1;
            if (bit_cnt == 4'd7) begin
              byte_done = 1'b1;
            end
          end
          if (shift_edge) begin
            // bit_cnt==8 means the byte is finished: this shift edge starts the
            // next byte with a fresh reload. In cpha=1 the first leading edge of
            // a byte is skipped because bit 7 is already on miso.
            if (bit_cnt == 4'd8) begin
              do_reload = 1'b1;
            end else if (!(cpha && (bit_cnt == 4'd0))) begin
              do_shift = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit counter and receive shift register
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt  <= '0;
      shift_rx <= '0;
    end else if (clr_cnt) begin
      bit_cnt <= '0;
    end else if (do_load) begin
      bit_cnt  <= '0;
      shift_rx <= '0;
    end else if (do_sample) begin
      bit_cnt  <= bit_cnt + 4'd1;
      shift_rx <= rx_byte;
    end else if (do_reload) begin
      bit_cnt <= '0;
    end
  end

  // Transmit shift register and single-entry holding buffer
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_tx <= '0;
      tx_buf   <= '0;
      tx_ready <= 1'b1;
    end else if (reload_any) begin
      // shift_tx takes the old buffer content (or zero if empty); a
      // simultaneous tx_load into an empty buffer is still accepted
      shift_tx <= tx_ready ? 8'h00 : tx_buf;
      if (tx_ready && tx_load) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end else begin
        tx_ready <= 1'b1;
      end
    end else begin
      if (do_shift) begin
        shift_tx <= {shift_tx[6:0], 1'b0};
      end
      if (tx_load && tx_ready) begin
        tx_buf   <= tx_data;
        tx_ready <= 1'b0;
      end
    end
  end

  // Receive handshake: deliver completed bytes, flag drops, clear on ack
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end else if (byte_done) begin
      if (!rx_valid || rx_ack) begin
        rx_data  <= rx_byte;
        rx_valid <= 1'b1;
        if (rx_ack) begin
          overrun <= 1'b0;
        end
      end else begin
        overrun <= 1'b1;
      end
    end else if (rx_ack) begin
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
    end
  end

  // miso carries the transmit MSB only while a transfer is active
  always_comb begin
    miso = (state == SHIFT) ? shift_tx[7] : 1'b0;
  end

endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: directed bench for spi_slave in mode 0 (dut0) and mode 3 (dut1).
module tb_spi_slave;

  localparam int H = 4;  // sclk half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic       sclk0, ss0, sclk1, ss1, mosi;
  logic [7:0] tx_data;
  logic       tx_load0, tx_load1, rx_ack0, rx_ack1;
  logic       miso0, miso1, tx_ready0, tx_ready1;
  logic       rx_valid0, rx_valid1, overrun0, overrun1;
  logic [7:0] rx_data0, rx_data1;

  int n_tests = 0;
  int n_fail  = 0;
  int rxv0_rises = 0;
  logic rxv0_q = 1'b0;

  always #5 clk = ~clk;

  spi_slave #(.cpol(1'b0), .cpha(1'b0)) dut0 (
    .clk(clk), .rst(rst), .sclk(sclk0), .ss(ss0), .mosi(mosi), .miso(miso0),
    .tx_data(tx_data), .tx_load(tx_load0), .tx_ready(tx_ready0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .rx_ack(rx_ack0), .overrun(overrun0)
  );

  spi_slave #(.cpol(1'b1), .cpha(1'b1)) dut1 (
    .clk(clk), .rst(rst), .sclk(sclk1), .ss(ss1), .mosi(mosi), .miso(miso1),
    .tx_data(tx_data), .tx_load(tx_load1), .tx_ready(tx_ready1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .rx_ack(rx_ack1), .overrun(overrun1)
  );

  // count rx_valid assertions on dut0
  always @(posedge clk) begin
    if (rx_valid0 && !rxv0_q) rxv0_rises++;
    rxv0_q <= rx_valid0;
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic spi_begin(input int m);
    if (m == 0) ss0 = 1'b0; else ss1 = 1'b0;
    step(6);
  endtask

  task automatic spi_end(input int m);
    if (m == 0) ss0 = 1'b1; else ss1 = 1'b1;
    step(8);
  endtask

  // m=0: cpol0/cpha0; m=1: cpol1/cpha1. Shifts nbits MSB-first.
  task automatic spi_bits(input int m, input logic [7:0] tx, input int nbits,
                          output logic [7:0] rx);
    rx = '0;
    if (m == 0) begin
      mosi = tx[7];
      step(1);
      for (int i = 0; i < nbits; i++) begin
        rx[7-i] = miso0;
        sclk0 = 1'b1;
        step(H);
        sclk0 = 1'b0;
        if (i < 7) mosi = tx[6-i];
        step(H);
      end
    end else begin
      for (int i = 0; i < nbits; i++) begin
        sclk1 = 1'b0;
        mosi  = tx[7-i];
        step(H);
        rx[7-i] = miso1;
        sclk1 = 1'b1;
        step(H);
      end
    end
  endtask

  task automatic pulse_load(input int m, input logic [7:0] d);
    tx_data = d;
    if (m == 0) tx_load0 = 1'b1; else tx_load1 = 1'b1;
    step(1);
    tx_load0 = 1'b0;
    tx_load1 = 1'b0;
  endtask

  task automatic pulse_ack(input int m);
    if (m == 0) rx_ack0 = 1'b1; else rx_ack1 = 1'b1;
    step(1);
    rx_ack0 = 1'b0;
    rx_ack1 = 1'b0;
  endtask

  logic [7:0] r, r1, r2;

  initial begin
    rst = 1'b1; sclk0 = 1'b0; sclk1 = 1'b1; ss0 = 1'b1; ss1 = 1'b1;
    mosi = 1'b0; tx_data = '0; tx_load0 = 1'b0; tx_load1 = 1'b0;
    rx_ack0 = 1'b0; rx_ack1 = 1'b0;
    step(3);
    rst = 1'b0;
    step(2);

    // reset state
    check("rst_miso0",     miso0,     1'b0);
    check("rst_rx_data0",  rx_data0,  8'h00);
    check("rst_rx_valid0", rx_valid0, 1'b0);
    check("rst_overrun0",  overrun0,  1'b0);
    check("rst_tx_ready0", tx_ready0, 1'b1);
    check("rst_tx_ready1", tx_ready1, 1'b1);

    // single byte, mode 0
    pulse_load(0, 8'hA5);
    check("t1_tx_ready_full", tx_ready0, 1'b0);
    spi_begin(0);
    spi_bits(0, 8'h3C, 8, r);
    spi_end(0);
    check("t1_rx_data",  rx_data0,  8'h3C);
    check("t1_rx_valid", rx_valid0, 1'b1);
    check("t1_rises",    8'(rxv0_rises), 8'd1);
    check("t1_master_rx", r, 8'hA5);
    check("t1_tx_ready", tx_ready0, 1'b1);
    check("t1_overrun",  overrun0,  1'b0);
    pulse_ack(0);
    check("t1_ack_clears", rx_valid0, 1'b0);

    // two back-to-back bytes, mode 3
    pulse_load(1, 8'hC3);
    spi_begin(1);
    check("t2_preload_taken", tx_ready1, 1'b1);
    pulse_load(1, 8'h55);
    check("t2_buf_full", tx_ready1, 1'b0);
    spi_bits(1, 8'h81, 8, r1);
    check("t2_rx_valid_b1", rx_valid1, 1'b1);
    check("t2_rx_data_b1",  rx_data1,  8'h81);
    pulse_ack(1);
    check("t2_ack_clears", rx_valid1, 1'b0);
    spi_bits(1, 8'h7E, 8, r2);
    spi_end(1);
    check("t2_rx_data_b2",  rx_data1,  8'h7E);
    check("t2_rx_valid_b2", rx_valid1, 1'b1);
    check("t2_overrun",     overrun1,  1'b0);
    check("t2_master_b1",   r1, 8'hC3);
    check("t2_master_b2",   r2, 8'h55);
    check("t2_tx_ready",    tx_ready1, 1'b1);
    pulse_ack(1);

    // overrun with empty transmit buffer, mode 0
    spi_begin(0);
    spi_bits(0, 8'h11, 8, r1);
    spi_bits(0, 8'h22, 8, r2);
    spi_end(0);
    check("t3_rx_data",  rx_data0,  8'h11);
    check("t3_overrun",  overrun0,  1'b1);
    check("t3_rx_valid", rx_valid0, 1'b1);
    check("t3_empty_b1", r1, 8'h00);
    check("t3_empty_b2", r2, 8'h00);
    check("t3_tx_ready", tx_ready0, 1'b1);
    pulse_ack(0);
    check("t3_ack_valid",   rx_valid0, 1'b0);
    check("t3_ack_overrun", overrun0,  1'b0);

    // abort after 4 bits, then a full byte
    spi_begin(0);
    spi_bits(0, 8'hF0, 4, r);
    spi_end(0);
    check("t4_abort_valid",   rx_valid0, 1'b0);
    check("t4_abort_overrun", overrun0,  1'b0);
    check("t4_abort_miso",    miso0,     1'b0);
    pulse_load(0, 8'h96);
    spi_begin(0);
    spi_bits(0, 8'h0F, 8, r);
    spi_end(0);
    check("t4_rx_data",   rx_data0,  8'h0F);
    check("t4_rx_valid",  rx_valid0, 1'b1);
    check("t4_master_rx", r, 8'h96);
    pulse_ack(0);

    // reset at bit 5
    spi_begin(0);
    pulse_load(0, 8'h5A);
    spi_bits(0, 8'hFF, 5, r);
    check("t5_pre_tx_ready", tx_ready0, 1'b0);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    check("t5_miso",     miso0,     1'b0);
    check("t5_rx_data",  rx_data0,  8'h00);
    check("t5_rx_valid", rx_valid0, 1'b0);
    check("t5_overrun",  overrun0,  1'b0);
    check("t5_tx_ready", tx_ready0, 1'b1);
    step(6);
    spi_bits(0, 8'hE0, 3, r);
    spi_end(0);
    check("t5_no_valid", rx_valid0, 1'b0);
    check("total_rises", 8'(rxv0_rises), 8'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
